// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller (optional DCACHE_STATS_EN access/miss counters).
// Latency: load hit 0 cycles; a miss stalls through write-back (if dirty) and refill, then replays as a hit.
// Backpressure: cpu_stall_o freezes the pipeline; mem_req_o and mem_addr_o are held until mem_ack_i.
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]          access_cnt_o,
    output logic [31:0]          miss_cnt_o,
`endif
    input  logic                 mem_ack_i
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 27 - IDX_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_ALLOC = 2'd2;

    logic [1:0]           state;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] line_q [NUM_LINES];
    logic [IDX_W-1:0]     miss_idx;
    logic [TAG_W-1:0]     miss_tag;

    logic [2:0]       req_word;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             idle;
    logic             acc_done;
    logic             miss_start;
    logic             addr_lsb_unused;

    assign req_word        = cpu_addr_i[4:2];
    assign req_idx         = cpu_addr_i[5 +: IDX_W];
    assign req_tag         = cpu_addr_i[31 -: TAG_W];
    assign addr_lsb_unused = ^cpu_addr_i[1:0];

    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign idle       = (state == S_IDLE);
    assign acc_done   = cpu_req_i && idle && hit;
    assign miss_start = cpu_req_i && idle && !hit;

    assign cpu_stall_o = cpu_req_i && !(idle && hit);
    assign mem_req_o   = (state == S_WB) || (state == S_ALLOC);
    assign mem_we_o    = (state == S_WB);

    always_comb begin
        cpu_data_o = '0;
        if (acc_done && !cpu_we_i) begin
            cpu_data_o = line_q[req_idx][32*int'(req_word) +: 32];
        end
    end

    // Memory side works only from the latched miss index/tag, never the live CPU address.
    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        case (state)
            S_WB: begin
                mem_addr_o = {tag_q[miss_idx], miss_idx, 5'b0};
                mem_data_o = line_q[miss_idx];
            end
            S_ALLOC: mem_addr_o = {miss_tag, miss_idx, 5'b0};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            miss_idx <= '0;
            miss_tag <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_start) begin
                        miss_idx <= req_idx;
                        miss_tag <= req_tag;
                        state    <= dirty_q[req_idx] ? S_WB : S_ALLOC;
                    end else if (acc_done && cpu_we_i) begin
                        dirty_q[req_idx] <= 1'b1;
                    end
                end
                S_WB: begin
                    if (mem_ack_i) state <= S_ALLOC;
                end
                S_ALLOC: begin
                    if (mem_ack_i) begin
                        valid_q[miss_idx] <= 1'b1;
                        dirty_q[miss_idx] <= 1'b0;
                        state             <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (state == S_ALLOC && mem_ack_i) begin
            tag_q[miss_idx]  <= miss_tag;
            line_q[miss_idx] <= mem_data_i;
        end else if (acc_done && cpu_we_i) begin
            line_q[req_idx][32*int'(req_word) +: 32] <= cpu_data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            access_cnt_o <= '0;
            miss_cnt_o   <= '0;
        end else begin
            if (acc_done)   access_cnt_o <= access_cnt_o + 32'd1;
            if (miss_start) miss_cnt_o   <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule
